warp_xwb: RTL
=============

WARP_XWB -- requirements
Module: warp_xwb

Interface
REQ-001 SHALL have ports: i_clk  in  1  clock, all state on rising edge.
REQ-002 SHALL have: i_rst  in  1  asynchronous active-high reset.
REQ-003 SHALL have: i_alu_valid  in  1 / i_alu_rd  in  5 / i_alu_data  in  64, the single-cycle arith/logic result, never back-pressured.
REQ-004 SHALL have: i_lng_valid  in  1 / o_lng_ready  out  1 / i_lng_rd  in  5 / i_lng_data  in  64, the multi-cycle unit result, valid/ready handshake.
REQ-005 SHALL have: i_issue_valid  in  1 / i_issue_rd  in  5, marks a long-latency op destination as pending.
REQ-006 SHALL have: o_rd1_wen  out  1 / o_rd1_addr  out  5 / o_rd1_wdata  out  64, driving register-file write port 1 (ALU path).
REQ-007 SHALL have: o_rd2_wen  out  1 / o_rd2_addr  out  5 / o_rd2_wdata  out  64, driving register-file write port 2 (long path).
REQ-008 SHALL have: o_busy  out  32, scoreboard of pending destinations, bit n = xn.

Function
REQ-009 ALU path SHALL register inputs: o_rd1_* valid exactly 1 cycle after i_alu_valid sampled high.
REQ-010 o_rd1_wen SHALL be 0 when i_alu_valid=0 or i_alu_rd=0; addr/data still registered.
REQ-011 Long path SHALL buffer results in a 4-entry FIFO; transfer occurs when i_lng_valid & o_lng_ready at a rising edge.
REQ-012 o_lng_ready SHALL equal (count != 4), from registered count only; no combinational path from i_lng_valid.
REQ-013 FIFO head SHALL pop every cycle it is non-empty; popped entry appears on o_rd2_* next cycle; min accept-to-write latency 2 cycles.
REQ-014 Pushes and pops in the same cycle SHALL leave count unchanged; pointers wrap modulo 4.
REQ-015 o_rd2_wen SHALL be 0 when FIFO empty, popped rd=0, or popped rd equals i_alu_rd with i_alu_valid=1 in the pop cycle (ALU write wins; long entry dropped, still popped).
REQ-016 Entries with rd=0 SHALL be accepted and popped but never written.
REQ-017 i_issue_valid with i_issue_rd!=0 SHALL set o_busy[rd] at the next edge.
REQ-018 A pop (written or dropped) SHALL clear o_busy[popped rd] at the same edge.
REQ-019 Set and clear of the same bit in one cycle: set SHALL win.
REQ-020 o_busy[0] SHALL be constant 0.
REQ-021 Issue logic guarantees no WAW beyond REQ-015; block performs no further ordering.

Reset
REQ-022 On i_rst high, immediately: FIFO count 0, pointers 0, o_busy=0, o_rd1_wen=0, o_rd2_wen=0, addr/data outputs 0, o_lng_ready=1 after first edge following deassert.
REQ-023 Reset mid-operation SHALL discard all buffered entries and pending bits; no write issued for them after release.
REQ-024 o_lng_ready SHALL be 0 while i_rst is high.

Configuration
REQ-025 Macro WARP_XWB_FORWARD_EN SHALL, when defined, add ports i_fwd_addr  in  5, o_fwd_hit  out  1, o_fwd_data  out  64.
REQ-026 With it: o_fwd_hit combinationally = (o_rd1_wen & o_rd1_addr==i_fwd_addr) | (o_rd2_wen & o_rd2_addr==i_fwd_addr); o_fwd_data from port 1 if it matches, else port 2, else 0; i_fwd_addr=0 never hits.
REQ-027 Without it: those ports SHALL not exist and no forwarding logic is built; all other behaviour identical.

Verification
REQ-028 ALU: i_alu_valid=1, rd=5, data=0x1234 -> next cycle o_rd1_wen=1, addr=5, wdata=0x1234; rd=0 -> o_rd1_wen=0.
REQ-029 Long fill: issue rd 1..5, hold i_lng_valid=1 with o_rd2 pops stalled by pre-filling 4 in back-to-back cycles -> o_lng_ready stays 1 while popping; results rd=1..5 appear on o_rd2 in order, each 2+ cycles after accept, busy bits clear on pop.
REQ-030 Conflict: FIFO head rd=7 pops while i_alu_valid=1, rd=7, data=0xAA -> o_rd1 writes 0xAA, o_rd2_wen=0, o_busy[7] clears.
REQ-031 Scoreboard: i_issue_rd=9 same cycle as pop of rd=9 -> o_busy[9]=1 afterwards; i_issue_rd=0 -> o_busy=0.
REQ-032 Reset with 3 entries buffered and busy=0x0E -> all outputs 0, no o_rd2_wen after release, o_lng_ready=1.
REQ-033 With WARP_XWB_FORWARD_EN: o_rd1 rd=3 data=0x11 and o_rd2 rd=3 data=0x22 same cycle, i_fwd_addr=3 -> o_fwd_hit=1, o_fwd_data=0x11; i_fwd_addr=4 -> hit=0, data=0.

Source files
------------

// File: rtl/warp_xwb.sv
// Writeback merge stage: registered ALU write port, 4-entry buffered long-latency port
// and a pending-destination scoreboard. Optional read-forwarding under WARP_XWB_FORWARD_EN.
module warp_xwb (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_alu_valid,
    input  logic [4:0]  i_alu_rd,
    input  logic [63:0] i_alu_data,
    input  logic        i_lng_valid,
    output logic        o_lng_ready,
    input  logic [4:0]  i_lng_rd,
    input  logic [63:0] i_lng_data,
    input  logic        i_issue_valid,
    input  logic [4:0]  i_issue_rd,
    output logic        o_rd1_wen,
    output logic [4:0]  o_rd1_addr,
    output logic [63:0] o_rd1_wdata,
    output logic        o_rd2_wen,
    output logic [4:0]  o_rd2_addr,
    output logic [63:0] o_rd2_wdata,
    output logic [31:0] o_busy
`ifdef WARP_XWB_FORWARD_EN
    ,
    input  logic [4:0]  i_fwd_addr,
    output logic        o_fwd_hit,
    output logic [63:0] o_fwd_data
`endif
);

    logic [4:0]  fifo_rd   [4];
    logic [63:0] fifo_data [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  count, count_next;
    logic        ready_q;
    logic        push, pop, conflict;
    logic [4:0]  head_rd;
    logic [31:0] set_mask, clr_mask, busy_next;

    assign o_lng_ready = ready_q;
    assign push        = i_lng_valid & ready_q;
    assign pop         = (count != 3'd0);
    assign head_rd     = fifo_rd[rd_ptr];
    // The ALU write to the same register in the pop cycle is the younger value.
    assign conflict    = i_alu_valid && (i_alu_rd == head_rd);

    always_comb begin
        count_next = count;
        set_mask   = '0;
        clr_mask   = '0;
        case ({push, pop})
            2'b10:   count_next = count + 3'd1;
            2'b01:   count_next = count - 3'd1;
            default: count_next = count;
        endcase
        if (pop)
            clr_mask = 32'd1 << head_rd;
        if (i_issue_valid && i_issue_rd != 5'd0)
            set_mask = 32'd1 << i_issue_rd;
        busy_next = ((o_busy & ~clr_mask) | set_mask) & ~32'd1;
    end

    // NOTE: the FIFO storage carries no reset; occupancy is tracked by count and
    // pointers, so stale contents are never observed and the array maps to plain RAM.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= i_lng_rd;
            fifo_data[wr_ptr] <= i_lng_data;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register samples
    // pre-edge values, matching the hardware regardless of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            ready_q     <= 1'b0;
            o_busy      <= '0;
            o_rd1_wen   <= 1'b0;
            o_rd1_addr  <= '0;
            o_rd1_wdata <= '0;
            o_rd2_wen   <= 1'b0;
            o_rd2_addr  <= '0;
            o_rd2_wdata <= '0;
        end else begin
            o_rd1_wen   <= i_alu_valid && (i_alu_rd != 5'd0);
            o_rd1_addr  <= i_alu_rd;
            o_rd1_wdata <= i_alu_data;

            o_rd2_wen <= pop && (head_rd != 5'd0) && !conflict;
            if (pop) begin
                o_rd2_addr  <= head_rd;
                o_rd2_wdata <= fifo_data[rd_ptr];
                rd_ptr      <= rd_ptr + 2'd1;
            end
            if (push)
                wr_ptr <= wr_ptr + 2'd1;

            count   <= count_next;
            ready_q <= (count_next != 3'd4);
            o_busy  <= busy_next;
        end
    end

`ifdef WARP_XWB_FORWARD_EN
    logic hit1, hit2;

    always_comb begin
        hit1       = o_rd1_wen && (o_rd1_addr == i_fwd_addr) && (i_fwd_addr != 5'd0);
        hit2       = o_rd2_wen && (o_rd2_addr == i_fwd_addr) && (i_fwd_addr != 5'd0);
        o_fwd_hit  = hit1 | hit2;
        o_fwd_data = '0;
        if (hit1)
            o_fwd_data = o_rd1_wdata;
        else if (hit2)
            o_fwd_data = o_rd2_wdata;
    end
`endif

endmodule
